alu_seq: RTL and testbench
==========================

Name: alu_seq

Overview:
- Parametrised, handshaked successor to the combinational 6502-style ALU; sits between decode/operand fetch and accumulator/status writeback.
- Registers every result and adds WIDTH generalisation, CMP, and nibble-serial BCD ADC/SBC when status D=1.
- Valid/ready on both sides, so the sequencer can stall it.

Parameters:
- WIDTH, 8, datapath width in bits; must be a multiple of 4 when DECIMAL_EN=1.
- DECIMAL_EN, 1, 1 = honour status D for ADC/SBC; 0 = always binary.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  reset, asynchronous, active-low (asserted at 0).
- in_valid  in  1  op/operands presented.
- in_ready  out  1  block can accept this cycle.
- op  in  4  opcode: ADD=0 ADC=1 SBC=2 AND=3 EOR=4 ORA=5 BIT=6 ASL=7 LSR=8 ROL=9 ROR=10 CMP=11; 12-15 illegal.
- accumulator  in  WIDTH  operand A.
- operand_2  in  WIDTH  operand B.
- status  in  8  flags [7]C [6]Z [5]I [4]D [3]B [2]V [1]N [0]reserved.
- out_valid  out  1  result/status_out valid.
- out_ready  in  1  consumer accepts.
- result  out  WIDTH  registered result.
- status_out  out  8  registered flags, same bit map.
- illegal_op  out  1  qualified by out_valid; op was 12-15.

Behaviour:
- Reset (rst=0, async): state IDLE; result=0, status_out=0, out_valid=0, illegal_op=0; any in-flight op is discarded. in_ready=1 after reset release.
- FSM states:
  - IDLE: in_ready=1.
  - BCD: in_ready=0; one nibble per cycle.
  - DONE: out_valid=1; in_ready=out_ready.
- Accept: in_valid&&in_ready at an edge. Operands, op, and status are captured at that edge.
- Binary path: next state DONE; out_valid rises the cycle after accept (latency 1).
- Decimal path (DECIMAL_EN&&D&&op in {ADC,SBC}): go to BCD with nibble index k=0. Each cycle processes nibble k using the carry/borrow from nibble k-1; after k=WIDTH/4-1, go to DONE. Latency = 1+WIDTH/4 (3 at WIDTH=8).
- In DONE:
  - out_ready=0: hold result/status_out/out_valid stable.
  - out_ready=1 and accept: start the new op; out_valid stays 1 if the new op is binary (throughput one per cycle).
  - out_ready=1 and no accept: go to IDLE, out_valid=0.
- Arithmetic (c = status C):
  - ADD: A+B.
  - ADC: A+B+c.
  - SBC: A+~B+c.
  - CMP: A+~B+1; result=A; C=(A>=B unsigned); V unchanged.
  - Sums are WIDTH+1 bits; C=bit WIDTH. V=(A[msb]==B'[msb])&&(R[msb]!=A[msb]), where B' is the value actually added.
- BCD digit rules:
  - ADC: s=a+b+cy; if s>9 then digit=(s-10)[3:0], cy=1.
  - SBC: d=a-b-bw; if d<0 then digit=(d+10)[3:0], bw=1; initial bw=~c; final C=~bw.
  - Invalid digits follow the same arithmetic; no error is flagged.
  - Z and N come from the final decimal result. V comes from the binary sum computed at accept.
- Logic:
  - AND/EOR/ORA on A,B.
  - BIT: result=A; Z=((A&B)==0); N=B[W-1]; V=B[W-2].
- Shifts operate on B:
  - ASL shifts in 0; C=B[W-1].
  - LSR shifts in 0; C=B[0]; N=0.
  - ROL shifts in c; C=B[W-1].
  - ROR shifts in c; C=B[0].
- Flags not listed for an op pass through from captured status. I, D, B and bit0 always pass through.
- Z=(result==0) and N=result[W-1] for all ops except BIT and CMP. CMP sets Z and N from the difference.
- Illegal op: result=A, status_out=status, illegal_op=1, latency 1.
- in_valid while in_ready=0 is ignored. The upstream holds its request.

Decomposition:
- Package alu_pkg holds:
  - opcode localparams;
  - status bit indices (C_BIT=7 … N_BIT=1);
  - FSM state encoding (IDLE, BCD, DONE).
- Sub-module bcd_digit: combinational one-nibble add/sub with carry/borrow in/out and a mode input. It is instantiated once and reused serially by the BCD state.

Test Plan:
- ADC binary, A=0x50, B=0x50, C=0 -> out_valid exactly 1 cycle after accept; result=0xA0, V=1, N=1, C=0, Z=0.
- Decimal ADC, D=1, A=0x58, B=0x46, C=1 -> result=0x05, C=1, Z=0; out_valid 3 cycles after accept; in_ready=0 during the BCD cycles.
- Decimal SBC, D=1, A=0x12, B=0x21, C=1 -> result=0x91, C=0, N=1.
- Shifts:
  - ROR with B=0x01, C=1 -> 0x80, C=1, N=1.
  - ASL with B=0x80 -> 0x00, C=1, Z=1.
  - CMP with A=0x10, B=0x10 -> result=0x10, Z=1, C=1.
- Backpressure: hold out_ready=0 for 3 cycles -> outputs stable, in_ready=0. Then out_ready=1 with AND, ORA, EOR presented back-to-back -> one result per cycle, no drops or duplicates.
- Reset mid-BCD: assert rst=0 during the second BCD cycle -> out_valid, result and status_out go to 0 immediately. After release, op=13 -> result=A, illegal_op=1, status unchanged.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcodes, status bit positions and FSM encoding for the sequential ALU.
package alu_pkg;

   localparam logic [3:0] OP_ADD = 4'd0;
   localparam logic [3:0] OP_ADC = 4'd1;
   localparam logic [3:0] OP_SBC = 4'd2;
   localparam logic [3:0] OP_AND = 4'd3;
   localparam logic [3:0] OP_EOR = 4'd4;
   localparam logic [3:0] OP_ORA = 4'd5;
   localparam logic [3:0] OP_BIT = 4'd6;
   localparam logic [3:0] OP_ASL = 4'd7;
   localparam logic [3:0] OP_LSR = 4'd8;
   localparam logic [3:0] OP_ROL = 4'd9;
   localparam logic [3:0] OP_ROR = 4'd10;
   localparam logic [3:0] OP_CMP = 4'd11;

   localparam int C_BIT = 7;
   localparam int Z_BIT = 6;
   localparam int I_BIT = 5;
   localparam int D_BIT = 4;
   localparam int B_BIT = 3;
   localparam int V_BIT = 2;
   localparam int N_BIT = 1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BCD  = 2'd1,
      ST_DONE = 2'd2
   } alu_state_e;

endpackage

// File: rtl/bcd_digit.sv
// One decimal digit of BCD add (carry in/out) or subtract (borrow in/out).
// Out-of-range input digits go through the same arithmetic unflagged.
module bcd_digit (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       cin,
   input  logic       sub,
   output logic [3:0] digit,
   output logic       cout
);

   logic [4:0] sum;
   logic [4:0] diff;

   // Digit sum/difference with decimal correction; diff[4] is the sign of a-b-bw.
   always_comb begin
      sum   = {1'b0, a} + {1'b0, b} + {4'd0, cin};
      diff  = {1'b0, a} - {1'b0, b} - {4'd0, cin};
      digit = sum[3:0];
      cout  = 1'b0;
      if (sub) begin
         cout  = diff[4];
         digit = diff[4] ? diff[3:0] + 4'd10 : diff[3:0];
      end else begin
         cout  = (sum > 5'd9);
         digit = (sum > 5'd9) ? sum[3:0] - 4'd10 : sum[3:0];
      end
   end

endmodule

// File: rtl/alu_seq.sv
// Registered, handshaked 6502-style ALU with nibble-serial decimal ADC/SBC.
//
//  state   | meaning
//  --------+------------------------------------------------------------
//  ST_IDLE | nothing held, ready for an op
//  ST_BCD  | decimal ADC/SBC in flight, one nibble per cycle, not ready
//  ST_DONE | result held with out_valid; ready only when consumer is
module alu_seq
   import alu_pkg::*;
#(
   parameter int WIDTH      = 8,
   parameter bit DECIMAL_EN = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       op,
   input  logic [WIDTH-1:0] accumulator,
   input  logic [WIDTH-1:0] operand_2,
   input  logic [7:0]       status,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic [7:0]       status_out,
   output logic             illegal_op
);

   localparam int MSB  = WIDTH - 1;
   localparam int NIBS = (WIDTH / 4 > 0) ? WIDTH / 4 : 1;
   localparam int CW   = (NIBS > 1) ? $clog2(NIBS) : 1;

   alu_state_e       state;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [WIDTH-1:0] bcd_acc;
   logic             cy_q;
   logic             sub_q;
   logic [7:0]       status_q;
   logic [CW-1:0]    nib_cnt;

   logic             accept;
   logic             dec_op;
   logic [WIDTH-1:0] b_eff;
   logic             add_cin;
   logic [WIDTH:0]   bin_sum;
   logic             bin_v;
   logic [WIDTH-1:0] nxt_res;
   logic [7:0]       nxt_st;
   logic             nxt_ill;
   logic             set_zn;
   logic [7:0]       dec_st;
   logic [3:0]       dig;
   logic             dig_cout;
   logic [WIDTH-1:0] bcd_next;
   logic [7:0]       fin_st;

   assign in_ready = (state == ST_IDLE) || ((state == ST_DONE) && out_ready);
   assign accept   = in_valid && in_ready;
   assign dec_op   = DECIMAL_EN && status[D_BIT] && ((op == OP_ADC) || (op == OP_SBC));

   // Adder operand selection: subtract-style ops add the complement of B.
   always_comb begin
      b_eff   = ((op == OP_SBC) || (op == OP_CMP)) ? ~operand_2 : operand_2;
      add_cin = 1'b0;
      case (op)
         OP_ADC, OP_SBC: add_cin = status[C_BIT];
         OP_CMP:         add_cin = 1'b1;
         default:        add_cin = 1'b0;
      endcase
   end

   assign bin_sum = {1'b0, accumulator} + {1'b0, b_eff} + (WIDTH + 1)'(add_cin);
   assign bin_v   = (accumulator[MSB] == b_eff[MSB]) && (bin_sum[MSB] != accumulator[MSB]);

   // Single-cycle result and flags for every binary op and for illegal opcodes.
   always_comb begin
      nxt_res = accumulator;
      nxt_st  = status;
      nxt_ill = 1'b0;
      set_zn  = 1'b1;
      case (op)
         OP_ADD, OP_ADC, OP_SBC: begin
            nxt_res       = bin_sum[WIDTH-1:0];
            nxt_st[C_BIT] = bin_sum[WIDTH];
            nxt_st[V_BIT] = bin_v;
         end
         OP_AND: nxt_res = accumulator & operand_2;
         OP_EOR: nxt_res = accumulator ^ operand_2;
         OP_ORA: nxt_res = accumulator | operand_2;
         OP_BIT: begin
            set_zn        = 1'b0;
            nxt_st[Z_BIT] = ~|(accumulator & operand_2);
            nxt_st[N_BIT] = operand_2[MSB];
            nxt_st[V_BIT] = operand_2[WIDTH-2];
         end
         OP_ASL: begin
            nxt_res       = {operand_2[WIDTH-2:0], 1'b0};
            nxt_st[C_BIT] = operand_2[MSB];
         end
         OP_LSR: begin
            nxt_res       = {1'b0, operand_2[WIDTH-1:1]};
            nxt_st[C_BIT] = operand_2[0];
         end
         OP_ROL: begin
            nxt_res       = {operand_2[WIDTH-2:0], status[C_BIT]};
            nxt_st[C_BIT] = operand_2[MSB];
         end
         OP_ROR: begin
            nxt_res       = {status[C_BIT], operand_2[WIDTH-1:1]};
            nxt_st[C_BIT] = operand_2[0];
         end
         OP_CMP: begin
            set_zn        = 1'b0;
            nxt_st[C_BIT] = bin_sum[WIDTH];
            nxt_st[Z_BIT] = ~|bin_sum[WIDTH-1:0];
            nxt_st[N_BIT] = bin_sum[MSB];
         end
         default: begin
            set_zn  = 1'b0;
            nxt_ill = 1'b1;
         end
      endcase
      if (set_zn) begin
         nxt_st[Z_BIT] = ~|nxt_res;
         nxt_st[N_BIT] = nxt_res[MSB];
      end
   end

   // Decimal ops keep V from the binary sum taken at accept time.
   always_comb begin
      dec_st        = status;
      dec_st[V_BIT] = bin_v;
   end

   bcd_digit u_bcd_digit (
      .a     (a_q[3:0]),
      .b     (b_q[3:0]),
      .cin   (cy_q),
      .sub   (sub_q),
      .digit (dig),
      .cout  (dig_cout)
   );

   // Digits enter at the top of the accumulator and shift down, so the last
   // nibble lands with every digit in place.
   assign bcd_next = WIDTH'({dig, bcd_acc} >> 4);

   // Final decimal flags: C is carry out for ADC, inverted borrow for SBC.
   always_comb begin
      fin_st        = status_q;
      fin_st[C_BIT] = sub_q ? ~dig_cout : dig_cout;
      fin_st[Z_BIT] = ~|bcd_next;
      fin_st[N_BIT] = bcd_next[MSB];
   end

   // Control FSM and all registered outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= ST_IDLE;
         a_q        <= '0;
         b_q        <= '0;
         bcd_acc    <= '0;
         cy_q       <= 1'b0;
         sub_q      <= 1'b0;
         status_q   <= '0;
         nib_cnt    <= '0;
         result     <= '0;
         status_out <= '0;
         out_valid  <= 1'b0;
         illegal_op <= 1'b0;
      end else begin
         case (state)
            ST_BCD: begin
               a_q     <= a_q >> 4;
               b_q     <= b_q >> 4;
               bcd_acc <= bcd_next;
               cy_q    <= dig_cout;
               if (nib_cnt == '0) begin
                  state      <= ST_DONE;
                  result     <= bcd_next;
                  status_out <= fin_st;
                  illegal_op <= 1'b0;
                  out_valid  <= 1'b1;
               end else begin
                  nib_cnt <= nib_cnt - CW'(1);
               end
            end
            ST_DONE: begin
               if (out_ready && !in_valid) begin
                  state     <= ST_IDLE;
                  out_valid <= 1'b0;
               end
            end
            default: ;
         endcase

         if (accept) begin
            if (dec_op) begin
               state     <= ST_BCD;
               out_valid <= 1'b0;
               a_q       <= accumulator;
               b_q       <= operand_2;
               sub_q     <= (op == OP_SBC);
               cy_q      <= (op == OP_SBC) ? ~status[C_BIT] : status[C_BIT];
               status_q  <= dec_st;
               nib_cnt   <= CW'(NIBS - 1);
            end else begin
               state      <= ST_DONE;
               out_valid  <= 1'b1;
               result     <= nxt_res;
               status_out <= nxt_st;
               illegal_op <= nxt_ill;
            end
         end
      end
   end

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: directed cases with literal expectations, backpressure,
// reset during a decimal op, then randomized traffic against an arithmetic model.
module tb_alu_seq;
   import alu_pkg::*;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         in_valid = 1'b0;
   logic         out_ready = 1'b1;
   logic [3:0]   op = 4'd0;
   logic [W-1:0] accumulator = '0;
   logic [W-1:0] operand_2 = '0;
   logic [7:0]   status = '0;
   logic         in_ready;
   logic         out_valid;
   logic         illegal_op;
   logic [W-1:0] result;
   logic [7:0]   status_out;

   int   n_chk = 0;
   int   n_err = 0;
   int   cyc = 0;
   int   n_hs = 0;
   logic tb_acc = 1'b0;

   typedef struct {
      logic [7:0] r;
      logic [7:0] s;
      logic       ill;
      int         rdy;
   } exp_t;
   exp_t q[$];

   alu_seq #(.WIDTH(W), .DECIMAL_EN(1'b1)) dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .op          (op),
      .accumulator (accumulator),
      .operand_2   (operand_2),
      .status      (status),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .result      (result),
      .status_out  (status_out),
      .illegal_op  (illegal_op)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   task automatic chk1(input string nm, input logic act, input logic exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %b, expected %b (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic chk8(input string nm, input logic [7:0] act, input logic [7:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %02h, expected %02h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic chk_int(input string nm, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   // Reference behaviour in plain integer arithmetic, 8-bit datapath.
   function automatic void model(input logic [3:0] o, input logic [7:0] a, input logic [7:0] b,
                                 input logic [7:0] s, output logic [7:0] r, output logic [7:0] so,
                                 output logic ill, output int lat);
      int c, sum, sv, cy, t;
      bit zn;
      c   = int'(s[7]);
      so  = s;
      r   = a;
      ill = 1'b0;
      lat = 1;
      zn  = 1'b1;
      case (o)
         OP_ADD, OP_ADC: begin
            cy    = (o == OP_ADC) ? c : 0;
            sum   = int'(a) + int'(b) + cy;
            sv    = int'($signed(a)) + int'($signed(b)) + cy;
            r     = sum[7:0];
            so[7] = (sum > 255);
            so[2] = (sv > 127) || (sv < -128);
            if (o == OP_ADC && s[4]) begin
               r = 8'h00;
               for (int k = 0; k < 2; k++) begin
                  t = int'((a >> (4 * k)) & 8'h0f) + int'((b >> (4 * k)) & 8'h0f) + cy;
                  if (t > 9) begin t = t - 10; cy = 1; end else cy = 0;
                  r = r | (8'(t & 15) << (4 * k));
               end
               so[7] = (cy != 0);
               lat   = 3;
            end
         end
         OP_SBC: begin
            sum   = int'(a) + (255 - int'(b)) + c;
            sv    = int'($signed(a)) - int'($signed(b)) - (1 - c);
            r     = sum[7:0];
            so[7] = (sum > 255);
            so[2] = (sv > 127) || (sv < -128);
            if (s[4]) begin
               cy = 1 - c;
               r  = 8'h00;
               for (int k = 0; k < 2; k++) begin
                  t = int'((a >> (4 * k)) & 8'h0f) - int'((b >> (4 * k)) & 8'h0f) - cy;
                  if (t < 0) begin t = t + 10; cy = 1; end else cy = 0;
                  r = r | (8'(t & 15) << (4 * k));
               end
               so[7] = (cy == 0);
               lat   = 3;
            end
         end
         OP_AND: r = a & b;
         OP_EOR: r = a ^ b;
         OP_ORA: r = a | b;
         OP_BIT: begin
            zn    = 1'b0;
            so[6] = ((a & b) == 8'h00);
            so[1] = b[7];
            so[2] = b[6];
         end
         OP_ASL: begin r = 8'((int'(b) * 2) & 255); so[7] = (b >= 8'h80); end
         OP_LSR: begin r = b / 2; so[7] = b[0]; end
         OP_ROL: begin r = 8'((int'(b) * 2 + c) & 255); so[7] = (b >= 8'h80); end
         OP_ROR: begin r = 8'(int'(b) / 2 + c * 128); so[7] = b[0]; end
         OP_CMP: begin
            zn    = 1'b0;
            so[7] = (a >= b);
            so[6] = (a == b);
            t     = (int'(a) - int'(b)) & 255;
            so[1] = (t >= 128);
         end
         default: begin
            zn  = 1'b0;
            ill = 1'b1;
         end
      endcase
      if (zn) begin
         so[6] = (r == 8'h00);
         so[1] = (r >= 8'h80);
      end
   endfunction

   logic       exp_ov;
   logic       exp_ir;
   exp_t       e_new;
   int         e_lat;

   // Cycle-by-cycle comparison of handshake and payload against the model queue.
   always @(negedge clk) begin
      if (rst) begin
         exp_ov = (q.size() > 0) && (cyc >= q[0].rdy);
         exp_ir = (q.size() == 0) || (exp_ov && out_ready);
         chk1("out_valid", out_valid, exp_ov);
         chk1("in_ready", in_ready, exp_ir);
         if (exp_ov && out_valid) begin
            chk8("result", result, q[0].r);
            chk8("status_out", status_out, q[0].s);
            chk1("illegal_op", illegal_op, q[0].ill);
         end
         tb_acc = in_valid && exp_ir;
         if (exp_ov && out_ready) begin
            void'(q.pop_front());
            n_hs++;
         end
         if (tb_acc) begin
            model(op, accumulator, operand_2, status, e_new.r, e_new.s, e_new.ill, e_lat);
            e_new.rdy = cyc + e_lat;
            q.push_back(e_new);
         end
      end else begin
         tb_acc = 1'b0;
      end
   end

   // Present one op; returns just after the edge that accepted it.
   task automatic issue(input logic [3:0] o, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] s);
      int n;
      op = o; accumulator = a; operand_2 = b; status = s; in_valid = 1'b1;
      n = 0;
      do begin @(negedge clk); n++; end while (!in_ready && n < 20);
      chk1("issue in_ready", in_ready, 1'b1);
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   // Wait for the result, check latency and literal values, then consume it.
   task automatic await_out(input string nm, input logic [7:0] er, input logic [7:0] es,
                            input logic eill, input int elat);
      int n;
      n = 0;
      do begin @(negedge clk); n++; end while (!out_valid && n < 20);
      chk_int({nm, " latency"}, n, elat);
      chk8({nm, " result"}, result, er);
      chk8({nm, " status"}, status_out, es);
      chk1({nm, " illegal"}, illegal_op, eill);
      @(posedge clk); #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1, "watchdog expired");
   end

   logic [7:0] m_r, m_s;
   logic       m_ill;
   int         m_lat;
   int         hs0;
   logic [3:0] bp_op [3];
   logic [7:0] bp_a  [3];
   logic [7:0] bp_b  [3];

   initial begin
      // Model pinned against hand-worked values.
      model(OP_ADC, 8'h50, 8'h50, 8'h00, m_r, m_s, m_ill, m_lat);
      chk8("model adc bin r", m_r, 8'hA0);
      chk8("model adc bin s", m_s, 8'h06);
      chk_int("model adc bin lat", m_lat, 1);
      model(OP_ADC, 8'h58, 8'h46, 8'h90, m_r, m_s, m_ill, m_lat);
      chk8("model adc dec r", m_r, 8'h05);
      chk8("model adc dec s", m_s, 8'h94);
      chk_int("model adc dec lat", m_lat, 3);
      model(OP_SBC, 8'h12, 8'h21, 8'h90, m_r, m_s, m_ill, m_lat);
      chk8("model sbc dec r", m_r, 8'h91);
      chk8("model sbc dec s", m_s, 8'h12);

      #2 rst = 1'b0;
      #1;
      chk1("reset out_valid", out_valid, 1'b0);
      chk8("reset result", result, 8'h00);
      chk8("reset status_out", status_out, 8'h00);
      chk1("reset illegal_op", illegal_op, 1'b0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      @(negedge clk);
      chk1("in_ready after reset", in_ready, 1'b1);
      @(posedge clk); #1;

      issue(OP_ADC, 8'h50, 8'h50, 8'h00);
      await_out("adc bin", 8'hA0, 8'h06, 1'b0, 1);
      issue(OP_ADC, 8'h58, 8'h46, 8'h90);
      await_out("adc dec", 8'h05, 8'h94, 1'b0, 3);
      issue(OP_SBC, 8'h12, 8'h21, 8'h90);
      await_out("sbc dec", 8'h91, 8'h12, 1'b0, 3);
      issue(OP_ROR, 8'h33, 8'h01, 8'h80);
      await_out("ror", 8'h80, 8'h82, 1'b0, 1);
      issue(OP_ASL, 8'h33, 8'h80, 8'h00);
      await_out("asl", 8'h00, 8'hC0, 1'b0, 1);
      issue(OP_CMP, 8'h10, 8'h10, 8'h00);
      await_out("cmp", 8'h10, 8'hC0, 1'b0, 1);

      // Backpressure: result must hold while the consumer stalls.
      out_ready = 1'b0;
      issue(OP_AND, 8'hF0, 8'h3C, 8'h24);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk1("bp out_valid held", out_valid, 1'b1);
         chk1("bp in_ready low", in_ready, 1'b0);
         chk8("bp result held", result, 8'h30);
         chk8("bp status held", status_out, 8'h24);
      end
      @(posedge clk); #1;
      hs0 = n_hs;
      bp_op[0] = OP_AND; bp_a[0] = 8'hC3; bp_b[0] = 8'h0F;
      bp_op[1] = OP_ORA; bp_a[1] = 8'h0F; bp_b[1] = 8'h50;
      bp_op[2] = OP_EOR; bp_a[2] = 8'hAA; bp_b[2] = 8'h55;
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         op = bp_op[i]; accumulator = bp_a[i]; operand_2 = bp_b[i]; status = 8'h24;
         in_valid = 1'b1;
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk_int("bp handshakes", n_hs - hs0, 4);

      // Reset in the second BCD cycle discards the op and clears outputs at once.
      op = OP_ADC; accumulator = 8'h58; operand_2 = 8'h46; status = 8'h90; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      q.delete();
      #1;
      chk1("mid-bcd reset out_valid", out_valid, 1'b0);
      chk8("mid-bcd reset result", result, 8'h00);
      chk8("mid-bcd reset status", status_out, 8'h00);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      issue(4'd13, 8'h5A, 8'h11, 8'h3D);
      await_out("illegal", 8'h5A, 8'h3D, 1'b1, 1);

      // Randomized traffic; the request is held until it is taken.
      for (int i = 0; i < 1500; i++) begin
         if (!in_valid || tb_acc) begin
            in_valid    = ($urandom_range(0, 3) != 0);
            op          = 4'($urandom_range(0, 15));
            accumulator = 8'($urandom);
            operand_2   = 8'($urandom);
            status      = 8'($urandom);
         end
         out_ready = ($urandom_range(0, 3) != 0);
         @(posedge clk); #1;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      repeat (10) @(posedge clk);
      #1;
      chk_int("drain queue empty", q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
